regfile_sb: RTL and testbench

Parametrised successor to the single-cycle MIPS register file, intended for the pipelined datapath. It provides NUM_READ combinational read ports and one synchronous write port, with an optional hardwired-zero r0. It adds a write-to-read bypass and a pending-write scoreboard so that hazard logic can stall consumers of registers whose producers are still in flight. All state clears on asynchronous reset.

---
 rtl/regfile_sb.sv | 79 +++++++
 tb/tb_regfile_sb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with optional hardwired r0, write-to-read bypass and a
// pending-write scoreboard used by pipeline hazard logic to stall consumers.
module regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_READ = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we,
   input  logic [ADDR_W-1:0]            waddr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [NUM_READ*ADDR_W-1:0]   raddr,
   output logic [NUM_READ*DATA_W-1:0]   rdata,
   output logic [NUM_READ-1:0]          rbusy,
   input  logic                         issue_en,
   input  logic [ADDR_W-1:0]            issue_addr,
   output logic [ADDR_W:0]              pend_cnt
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   if (NUM_READ < 1 || NUM_READ > 4) begin : g_num_read_chk
      $error("regfile_sb: NUM_READ must be in 1..4");
   end

   logic [DATA_W-1:0] rf_q [Depth];
   logic [Depth-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_ok, iss_ok, set_new, clr_old;

   // r0 is neither writable nor issuable when hardwired to zero
   assign wr_ok  = we && !(ZERO_REG && (waddr == '0));
   assign iss_ok = issue_en && !(ZERO_REG && (issue_addr == '0));

   always_comb begin
      pend_d = pend_q;
      if (wr_ok) pend_d[waddr] = 1'b0;
      // Set applied last: a newly issued producer supersedes the completing one
      if (iss_ok) pend_d[issue_addr] = 1'b1;
   end

   // Incremental count tracks popcount(pend_d) without an adder tree
   assign set_new = iss_ok && !pend_q[issue_addr];
   assign clr_old = wr_ok && pend_q[waddr] && !(iss_ok && (issue_addr == waddr));

   always_comb begin
      cnt_d = cnt_q + (ADDR_W + 1)'(set_new) - (ADDR_W + 1)'(clr_old);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < Depth; i++) rf_q[i] <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) rf_q[waddr] <= wdata;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_cnt = cnt_q;

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              zero_hit, byp_hit;

      assign ra       = raddr[i*ADDR_W +: ADDR_W];
      assign zero_hit = ZERO_REG && (ra == '0);
      assign byp_hit  = BYPASS && we && (waddr == ra);

      assign rdata[i*DATA_W +: DATA_W] = zero_hit ? '0 : (byp_hit ? wdata : rf_q[ra]);
      assign rbusy[i] = pend_q[ra] && !byp_hit && !zero_hit;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two instances (r0+bypass, plain) share stimulus; the stimulus
// process queues hand-computed expectations and a negedge monitor pops and compares.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  ra0 = '0, ra1 = '0;
   logic        issue_en = 1'b0;
   logic [4:0]  issue_addr = '0;
   logic [9:0]  raddr;
   logic [63:0] rdata_a, rdata_b;
   logic [1:0]  rbusy_a, rbusy_b;
   logic [5:0]  cnt_a, cnt_b;
   logic        chk = 1'b0;

   assign raddr = {ra1, ra0};

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
      .rdata(rdata_a), .rbusy(rbusy_a), .issue_en(issue_en), .issue_addr(issue_addr),
      .pend_cnt(cnt_a)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
      .rdata(rdata_b), .rbusy(rbusy_b), .issue_en(issue_en), .issue_addr(issue_addr),
      .pend_cnt(cnt_b)
   );

   typedef struct {
      string       name;
      logic [31:0] a0, a1;
      logic [1:0]  ab;
      logic [5:0]  ac;
      logic [31:0] b0, b1;
      logic [1:0]  bb;
      logic [5:0]  bc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         if (exp_q.size() == 0) begin
            cmp("queue_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            cmp({e.name, ".a.rdata0"}, rdata_a[31:0], e.a0);
            cmp({e.name, ".a.rdata1"}, rdata_a[63:32], e.a1);
            cmp({e.name, ".a.rbusy"}, 32'(rbusy_a), 32'(e.ab));
            cmp({e.name, ".a.pend_cnt"}, 32'(cnt_a), 32'(e.ac));
            cmp({e.name, ".b.rdata0"}, rdata_b[31:0], e.b0);
            cmp({e.name, ".b.rdata1"}, rdata_b[63:32], e.b1);
            cmp({e.name, ".b.rbusy"}, 32'(rbusy_b), 32'(e.bb));
            cmp({e.name, ".b.pend_cnt"}, 32'(cnt_b), 32'(e.bc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      chk = 1'b0;
   endtask

   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia,
                        input logic [4:0] r0, input logic [4:0] r1);
      we = w; waddr = wa; wdata = wd; issue_en = ie; issue_addr = ia; ra0 = r0; ra1 = r1;
   endtask

   task automatic expect_out(input string nm,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [1:0] ab, input logic [5:0] ac,
                             input logic [31:0] b0, input logic [31:0] b1,
                             input logic [1:0] bb, input logic [5:0] bc);
      exp_t e;
      e.name = nm; e.a0 = a0; e.a1 = a1; e.ab = ab; e.ac = ac;
      e.b0 = b0; e.b1 = b1; e.bb = bb; e.bc = bc;
      exp_q.push_back(e);
      chk = 1'b1;
   endtask

   initial begin
      step();
      drive(0, 0, 0, 0, 0, 5, 0);
      expect_out("reset", 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      step();
      rst_n = 1'b1;
      drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 3);
      expect_out("wr5", 32'hDEADBEEF, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      step();
      drive(0, 0, 0, 1, 5, 5, 3);
      expect_out("rd5_iss5", 32'hDEADBEEF, 0, 2'b00, 0, 32'hDEADBEEF, 0, 2'b00, 0);
      step();
      drive(0, 0, 0, 0, 0, 5, 5);
      expect_out("busy5", 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 1,
                 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 1);
      step();
      rst_n = 1'b0;
      expect_out("async_reset", 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      step();
      rst_n = 1'b1;
      drive(1, 3, 32'h12345678, 0, 0, 3, 5);
      expect_out("wr3_same", 32'h12345678, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      step();
      drive(0, 0, 0, 0, 0, 3, 5);
      expect_out("wr3_next", 32'h12345678, 0, 2'b00, 0, 32'h12345678, 0, 2'b00, 0);
      step();
      drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 3);
      expect_out("r0_wr_iss", 0, 32'h12345678, 2'b00, 0, 0, 32'h12345678, 2'b00, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("r0_after", 0, 0, 2'b00, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1);
      step();
      drive(0, 0, 0, 1, 7, 7, 0);
      expect_out("iss7", 0, 0, 2'b00, 0, 0, 32'hFFFFFFFF, 2'b10, 1);
      step();
      drive(0, 0, 0, 0, 0, 7, 7);
      expect_out("busy7", 0, 0, 2'b11, 1, 0, 0, 2'b11, 2);
      step();
      drive(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);
      expect_out("wr7_same", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1, 0, 0, 2'b11, 2);
      step();
      drive(0, 0, 0, 0, 0, 7, 0);
      expect_out("wr7_next", 32'hA5A5A5A5, 0, 2'b00, 0, 32'hA5A5A5A5, 32'hFFFFFFFF, 2'b10, 1);
      step();
      drive(0, 0, 0, 1, 9, 9, 7);
      expect_out("iss9", 0, 32'hA5A5A5A5, 2'b00, 0, 0, 32'hA5A5A5A5, 2'b00, 1);
      step();
      drive(1, 9, 32'h0BADF00D, 1, 9, 9, 9);
      expect_out("simul9", 32'h0BADF00D, 32'h0BADF00D, 2'b00, 1, 0, 0, 2'b11, 2);
      step();
      drive(0, 0, 0, 0, 0, 9, 9);
      expect_out("simul9_next", 32'h0BADF00D, 32'h0BADF00D, 2'b11, 1,
                 32'h0BADF00D, 32'h0BADF00D, 2'b11, 2);
      step();
      drive(1, 12, 32'h1, 0, 0, 12, 9);
      expect_out("wr12_np", 32'h1, 32'h0BADF00D, 2'b10, 1, 0, 32'h0BADF00D, 2'b10, 2);
      step();
      drive(0, 0, 0, 0, 0, 12, 9);
      expect_out("wr12_next", 32'h1, 32'h0BADF00D, 2'b10, 1, 32'h1, 32'h0BADF00D, 2'b10, 2);
      step();
      rst_n = 1'b0;
      expect_out("reset2", 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
      step();
      rst_n = 1'b1;
      for (int a = 1; a < 32; a++) begin
         drive(0, 0, 0, 1, 5'(a), 0, 0);
         expect_out($sformatf("fill%0d", a), 0, 0, 2'b00, 6'(a - 1), 0, 0, 2'b00, 6'(a - 1));
         step();
      end
      drive(0, 0, 0, 1, 4, 4, 0);
      expect_out("fill_full", 0, 0, 2'b01, 31, 0, 0, 2'b01, 31);
      step();
      drive(0, 0, 0, 1, 0, 4, 0);
      expect_out("reiss4", 0, 0, 2'b01, 31, 0, 0, 2'b01, 31);
      step();
      drive(0, 0, 0, 0, 0, 4, 0);
      expect_out("max_cnt", 0, 0, 2'b01, 31, 0, 0, 2'b11, 32);
      step();
      step();
      step();
      cmp("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
